// File: rtl/bcd_count_if.sv
// Button/switch inputs and counter-control outputs of the BCD count sequencer.
// The driver side is the master; bcd_count_ctrl connects as the slave.
interface bcd_count_if;
  logic       i_start;
  logic       i_load;
  logic       i_dir;
  logic [3:0] i_data;
  logic [3:0] i_count;
  logic       o_cnt_en;
  logic       o_cnt_up;
  logic       o_cnt_load;
  logic [3:0] o_cnt_data;
  logic       o_tc;
  logic [2:0] o_state;

  modport master (
    output i_start, i_load, i_dir, i_data, i_count,
    input  o_cnt_en, o_cnt_up, o_cnt_load, o_cnt_data, o_tc, o_state
  );

  modport slave (
    input  i_start, i_load, i_dir, i_data, i_count,
    output o_cnt_en, o_cnt_up, o_cnt_load, o_cnt_data, o_tc, o_state
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Run/pause/load sequencer for a 4-bit BCD counter: button edge detection,
// tick prescaler, and wrap-or-stop terminal-count policy. All outputs registered.
//
//   state | meaning
//   IDLE  | stopped, waiting for start or load
//   RUN   | prescaler running, count strobe every TICK_DIV cycles
//   PAUSE | halted mid-count, start resumes with a full period
//   LOAD  | one-cycle load strobe to the counter
//   DONE  | terminal count reached with WRAP=0
module bcd_count_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter bit WRAP     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  bcd_count_if.slave  bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic              r_start_q;
  logic              r_load_q;
  logic              r_cnt_en;
  logic              r_cnt_up;
  logic              r_cnt_load;
  logic [3:0]        r_cnt_data;
  logic              r_tc;

  state_t            w_state_nxt;
  logic [TICK_W-1:0] w_tick_nxt;
  logic              w_en_nxt;
  logic              w_tc_nxt;
  logic              w_load_nxt;
  logic [3:0]        w_data_nxt;
  logic              w_se;
  logic              w_le;
  logic              w_bound;
  logic              w_tick_term;

  assign w_se        = bus.i_start & ~r_start_q;
  assign w_le        = bus.i_load & ~r_load_q;
  assign w_tick_term = (r_tick == TICK_LAST);
  // Boundary uses the registered direction, i.e. the one the counter sees.
  assign w_bound     = (r_cnt_up & (bus.i_count == 4'd9)) |
                       (~r_cnt_up & (bus.i_count == 4'd0));

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = '0;
    w_en_nxt    = 1'b0;
    w_tc_nxt    = 1'b0;
    w_load_nxt  = 1'b0;
    w_data_nxt  = r_cnt_data;
    case (r_state)
      S_LOAD: w_state_nxt = S_IDLE;
      default: begin
        if (w_le) begin
          w_state_nxt = S_LOAD;
          w_load_nxt  = 1'b1;
          w_data_nxt  = (bus.i_data > 4'd9) ? 4'd9 : bus.i_data;
        end else if (w_se) begin
          case (r_state)
            S_IDLE:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_PAUSE;
            S_PAUSE: w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
          endcase
        end else if (r_state == S_RUN) begin
          if (w_tick_term) begin
            if (WRAP || !w_bound) begin
              w_en_nxt = 1'b1;
              w_tc_nxt = w_bound;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_start_q  <= 1'b0;
      r_load_q   <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_cnt_up   <= 1'b1;
      r_cnt_load <= 1'b0;
      r_cnt_data <= 4'd0;
      r_tc       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_start_q  <= bus.i_start;
      r_load_q   <= bus.i_load;
      r_cnt_en   <= w_en_nxt;
      r_cnt_up   <= bus.i_dir;
      r_cnt_load <= w_load_nxt;
      r_cnt_data <= w_data_nxt;
      r_tc       <= w_tc_nxt;
    end
  end

  assign bus.o_cnt_en   = r_cnt_en;
  assign bus.o_cnt_up   = r_cnt_up;
  assign bus.o_cnt_load = r_cnt_load;
  assign bus.o_cnt_data = r_cnt_data;
  assign bus.o_tc       = r_tc;
  assign bus.o_state    = r_state;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl: WRAP=1 and WRAP=0 instances share stimulus,
// a behavioural model queues expected outputs, a monitor compares every cycle.
module tb_bcd_count_ctrl;
  localparam int TD = 4;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_LOAD = 3, ST_DONE = 4;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] data;
    logic       tc;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    int st;
    int phase;
    bit sq, lq, en, up, ld, tc;
    int data;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_count_if if_w ();
  bcd_count_if if_s ();

  bcd_count_ctrl #(.TICK_DIV(TD), .WRAP(1'b1)) u_dut_wrap (.i_clk(clk), .i_rst(rst), .bus(if_w));
  bcd_count_ctrl #(.TICK_DIV(TD), .WRAP(1'b0)) u_dut_stop (.i_clk(clk), .i_rst(rst), .bus(if_s));

  bit         s_rst, s_start, s_load, s_dir;
  logic [3:0] s_data, s_count;
  mdl_t       m_w, m_s;
  outs_t      q_w[$];
  outs_t      q_s[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;

  // Reference: 'phase' is the number of RUN cycles elapsed in the current period.
  function automatic mdl_t step(mdl_t m, bit wrap, bit r, bit start, bit load, bit dir,
                                int data, int count);
    mdl_t n;
    bit se, le, edge_val;
    n = m;
    if (r) begin
      n.st = ST_IDLE; n.phase = 0; n.sq = 0; n.lq = 0; n.en = 0;
      n.up = 1; n.ld = 0; n.data = 0; n.tc = 0;
      return n;
    end
    se = start && !m.sq;
    le = load && !m.lq;
    n.sq = start; n.lq = load; n.up = dir;
    n.en = 0; n.tc = 0; n.ld = 0; n.phase = 0;
    edge_val = m.up ? (count == 9) : (count == 0);
    if (m.st == ST_LOAD) n.st = ST_IDLE;
    else if (le) begin
      n.st = ST_LOAD; n.ld = 1; n.data = (data > 9) ? 9 : data;
    end else if (se) begin
      if (m.st == ST_RUN) n.st = ST_PAUSE;
      else if (m.st == ST_IDLE || m.st == ST_PAUSE) n.st = ST_RUN;
      else n.st = ST_IDLE;
    end else if (m.st == ST_RUN) begin
      if (m.phase + 1 == TD) begin
        if (wrap || !edge_val) begin n.en = 1; n.tc = edge_val; end
        else n.st = ST_DONE;
      end else n.phase = m.phase + 1;
    end
    return n;
  endfunction

  function automatic outs_t exp_of(mdl_t m);
    outs_t o;
    o.en = m.en; o.up = m.up; o.ld = m.ld; o.data = 4'(m.data); o.tc = m.tc; o.st = 3'(m.st);
    return o;
  endfunction

  task automatic tick1();
    @(negedge clk);
    cyc++;
    rst = s_rst;
    if_w.i_start = s_start; if_w.i_load = s_load; if_w.i_dir = s_dir;
    if_w.i_data = s_data;   if_w.i_count = s_count;
    if_s.i_start = s_start; if_s.i_load = s_load; if_s.i_dir = s_dir;
    if_s.i_data = s_data;   if_s.i_count = s_count;
    m_w = step(m_w, 1'b1, s_rst, s_start, s_load, s_dir, int'(s_data), int'(s_count));
    m_s = step(m_s, 1'b0, s_rst, s_start, s_load, s_dir, int'(s_data), int'(s_count));
    q_w.push_back(exp_of(m_w));
    q_s.push_back(exp_of(m_s));
  endtask

  task automatic run(int n);
    repeat (n) tick1();
  endtask

  task automatic cmp(string name, outs_t got, outs_t exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cyc=%0d got(en,up,ld,data,tc,st)=%0b,%0b,%0b,%0d,%0b,%0d exp=%0b,%0b,%0b,%0d,%0b,%0d",
                  name, cyc, got.en, got.up, got.ld, got.data, got.tc, got.st,
                  exp.en, exp.up, exp.ld, exp.data, exp.tc, exp.st);
  endtask

  initial begin : monitor
    outs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        g.en = if_w.o_cnt_en; g.up = if_w.o_cnt_up; g.ld = if_w.o_cnt_load;
        g.data = if_w.o_cnt_data; g.tc = if_w.o_tc; g.st = if_w.o_state;
        cmp("wrap_outs", g, q_w.pop_front());
      end
      if (q_s.size() > 0) begin
        g.en = if_s.o_cnt_en; g.up = if_s.o_cnt_up; g.ld = if_s.o_cnt_load;
        g.data = if_s.o_cnt_data; g.tc = if_s.o_tc; g.st = if_s.o_state;
        cmp("stop_outs", g, q_s.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    m_w = '{default: 0};
    m_s = '{default: 0};
    s_rst = 1; s_start = 0; s_load = 0; s_dir = 1; s_data = 4'd0; s_count = 4'd5;
    run(2);
    s_rst = 0; run(2);
    s_start = 1; run(20); s_start = 0; run(4);        // held start acts once
    s_start = 1; run(1); s_start = 0; run(10);        // pause
    s_start = 1; run(1); s_start = 0; run(6);         // resume, full period
    s_data = 4'd7;  s_load = 1; run(1); s_load = 0; run(3);
    s_data = 4'd12; s_load = 1; run(1); s_load = 0; run(3);
    s_data = 4'd3;  s_load = 1; s_start = 1; run(1); s_load = 0; s_start = 0; run(3);
    s_start = 1; run(1); s_start = 0; s_count = 4'd9; run(10);
    s_dir = 0; s_count = 4'd0; run(10);
    s_start = 1; run(1); s_start = 0; run(3);
    s_data = 4'd2; s_load = 1; run(1); s_load = 0; s_rst = 1; run(1); s_rst = 0; run(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  s_start = ~s_start;
      if ($urandom_range(0, 39) == 0) s_load = ~s_load;
      if ($urandom_range(0, 29) == 0) s_dir = ~s_dir;
      s_data = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: s_count = 4'd0;
        1: s_count = 4'd9;
        default: s_count = 4'($urandom_range(0, 15));
      endcase
      s_rst = ($urandom_range(0, 499) == 0);
      tick1();
    end
    s_rst = 0;
    @(posedge clk);
    #3;
    checks++;
    if (q_w.size() == 0 && q_s.size() == 0) passes++;
    else $display("FAIL drain got=%0d/%0d pending exp=0/0", q_w.size(), q_s.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
